// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: one-hot state
// encoding, parity-mode constants and a constant-evaluable ceil(log2).
package uart_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Never returns less than 1 so that counters always have at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_param_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; both stages
// come out of reset at RST_VAL so an idle-high line produces no false edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable data width, oversampling ratio,
// optional parity and stop length; reports parity and framing errors per frame.
module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  import uart_pkg::*;

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = clog2(SMAX);
  localparam int NW   = clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY_ODD == uart_pkg::PARITY_ODD);

  logic rx_s;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            perr;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (rx),
    .q   (rx_s)
  );

  // Odd parity inverts the even-parity error term.
  always_comb begin
    perr = 1'b0;
    if (PARITY_EN != 0) perr = (^b_q) ^ p_q ^ ODD;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    if (s_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_d     = '0;
          end
        end
        START: begin
          if (s_q == S_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        DATA: begin
          if (s_q == S_BIT) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        PARITY: begin
          if (s_q == S_BIT) begin
            p_d     = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        STOP: begin
          // Leaving at the stop sample point keeps the next start edge visible.
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            perr_d  = perr;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7-bit with
// two stop bits) share clock, reset and s_tick; a per-instance queue holds
// the expected {parity_err, frame_err, dout} of every frame sent.
module tb_uart_rx_param;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk
  localparam int W       = 11;

  logic clk, reset, s_tick;
  logic rx0, rx1, rx2;
  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  logic done0, done1, done2;
  logic perr0, perr1, perr2;
  logic ferr0, ferr1, ferr2;
  logic busy0, busy1, busy2;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int done0_cnt  = 0;
  int done1_cnt  = 0;
  int done2_cnt  = 0;
  logic done0_prev = 1'b0;
  logic done1_prev = 1'b0;
  logic done2_prev = 1'b0;
  logic busy2_prev = 1'b0;
  int cyc   = 0;
  int rise2 = 0;

  uart_rx_param #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0), .dout(dout0),
    .rx_done_tick(done0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  uart_rx_param #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1), .dout(dout1),
    .rx_done_tick(done1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  uart_rx_param #(.DBIT(7), .OVERSAMPLE(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx2), .dout(dout2),
    .rx_done_tick(done2), .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
  );

  // Clock and oversample strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit par_en, input bit par_bit,
                            input int stop_low, input int stop_high);
    set_rx(which, 1'b0);
    wait_clk(BIT_CLK);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      wait_clk(BIT_CLK);
    end
    if (par_en) begin
      set_rx(which, par_bit);
      wait_clk(BIT_CLK);
    end
    if (stop_low > 0) begin
      set_rx(which, 1'b0);
      wait_clk(stop_low);
    end
    set_rx(which, 1'b1);
    wait_clk(stop_high);
  endtask

  // Scoreboard monitors: pop and compare on every rx_done_tick
  always @(negedge clk) begin
    if (done0) begin
      check("done0_width", {31'b0, done0_prev}, 32'd0);
      if (exp0_q.size() == 0) check("done0_unexpected", 32'd1, 32'd0);
      else check("dut0_frame", {21'b0, perr0, ferr0, 1'b0, dout0}, {21'b0, exp0_q.pop_front()});
      done0_cnt++;
    end
    done0_prev = done0;
  end

  always @(negedge clk) begin
    if (done1) begin
      check("done1_width", {31'b0, done1_prev}, 32'd0);
      if (exp1_q.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
      else check("dut1_frame", {21'b0, perr1, ferr1, 1'b0, dout1}, {21'b0, exp1_q.pop_front()});
      done1_cnt++;
    end
    done1_prev = done1;
  end

  // Busy rises on the START entry tick; completion is 152 ticks later
  // (8 to mid-start, 7x16 data, 32 stop) = 608 clk.
  always @(negedge clk) begin
    cyc++;
    if (busy2 && !busy2_prev) rise2 = cyc;
    busy2_prev = busy2;
    if (done2) begin
      check("done2_width", {31'b0, done2_prev}, 32'd0);
      check("dut2_stop_timing", cyc - rise2, 32'd608);
      if (exp2_q.size() == 0) check("done2_unexpected", 32'd1, 32'd0);
      else check("dut2_frame", {21'b0, perr2, ferr2, 2'b0, dout2}, {21'b0, exp2_q.pop_front()});
      done2_cnt++;
    end
    done2_prev = done2;
  end

  initial begin
    reset = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    wait_clk(5);
    check("rst_dout0", {24'b0, dout0}, 32'd0);
    check("rst_done0", {31'b0, done0}, 32'd0);
    check("rst_perr0", {31'b0, perr0}, 32'd0);
    check("rst_ferr0", {31'b0, ferr0}, 32'd0);
    check("rst_busy0", {31'b0, busy0}, 32'd0);
    check("rst_dout1", {24'b0, dout1}, 32'd0);
    check("rst_dout2", {25'b0, dout2}, 32'd0);
    reset = 1'b0;
    wait_clk(20);

    // Back-to-back 8N1 frames
    exp0_q.push_back({2'b00, 9'h055});
    exp0_q.push_back({2'b00, 9'h0A3});
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 0, BIT_CLK);
    send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 0, BIT_CLK);
    wait_clk(10);
    check("b2b_count", done0_cnt, 32'd2);
    check("b2b_dout", {24'b0, dout0}, 32'h0A3);

    // Three-tick low glitch: false start only
    rx0 = 1'b0;
    wait_clk(10);
    check("glitch_busy_hi", {31'b0, busy0}, 32'd1);
    wait_clk(2);
    rx0 = 1'b1;
    wait_clk(BIT_CLK);
    check("glitch_busy_lo", {31'b0, busy0}, 32'd0);
    check("glitch_dout", {24'b0, dout0}, 32'h0A3);
    check("glitch_count", done0_cnt, 32'd2);

    // Stop bit low, then a clean frame
    exp0_q.push_back({2'b01, 9'h03C});
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 48, BIT_CLK);
    exp0_q.push_back({2'b00, 9'h001});
    send_frame(0, 9'h001, 8, 1'b0, 1'b0, 0, BIT_CLK);
    wait_clk(10);
    check("ferr_clear", {31'b0, ferr0}, 32'd0);
    check("ferr_count", done0_cnt, 32'd4);

    // Reset during data bit 4 of 0xFF
    rx0 = 1'b0;
    wait_clk(BIT_CLK);
    rx0 = 1'b1;
    wait_clk(4 * BIT_CLK + 32);
    check("mid_busy", {31'b0, busy0}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_dout", {24'b0, dout0}, 32'd0);
    check("async_busy", {31'b0, busy0}, 32'd0);
    check("async_done", {31'b0, done0}, 32'd0);
    check("async_ferr", {31'b0, ferr0}, 32'd0);
    check("async_perr", {31'b0, perr0}, 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(400);
    check("abort_count", done0_cnt, 32'd4);
    exp0_q.push_back({2'b00, 9'h081});
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 0, BIT_CLK);
    wait_clk(10);
    check("post_rst_count", done0_cnt, 32'd5);

    // Even parity: correct then wrong parity bit
    exp1_q.push_back({2'b00, 9'h00F});
    send_frame(1, 9'h00F, 8, 1'b1, 1'b0, 0, BIT_CLK);
    exp1_q.push_back({2'b10, 9'h00F});
    send_frame(1, 9'h00F, 8, 1'b1, 1'b1, 0, BIT_CLK);
    wait_clk(10);
    check("par_count", done1_cnt, 32'd2);

    // 7 data bits, two stop bits
    exp2_q.push_back({2'b00, 9'h07E});
    send_frame(2, 9'h07E, 7, 1'b0, 1'b0, 0, 2 * BIT_CLK);
    wait_clk(100);
    check("d7_count", done2_cnt, 32'd1);

    check("exp0_left", exp0_q.size(), 32'd0);
    check("exp1_left", exp1_q.size(), 32'd0);
    check("exp2_left", exp2_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
